// File: rtl/dma_seq.sv
// dma_seq: walks the PRD list of one AHCI command and turns it into a series of
// dma_req bursts for the MPMC DMA engine. Each burst is limited by what is left
// of the PRD, by C_MAX_XFER and, on transmit, by the room left in the current
// outbound DATA FIS. The SOF/EOF/data qualifiers mark where FIS chunks begin and end.
module dma_seq #(
    parameter int unsigned C_MAX_XFER  = 8192,
    parameter int unsigned C_FIS_BYTES = 8192
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cmd_start,
    input  logic        cmd_wrt,
    input  logic [3:0]  cmd_pm,
    input  logic        cmd_flush,
    input  logic        cmd_abort,
    input  logic        prd_valid,
    output logic        prd_ready,
    input  logic [31:0] prd_addr,
    input  logic [21:0] prd_len,
    input  logic        prd_last,
    output logic        dma_req,
    input  logic        dma_ack,
    output logic [31:0] dma_address,
    output logic [15:0] dma_length,
    output logic        dma_wrt,
    output logic        dma_sof,
    output logic        dma_eof,
    output logic        dma_data,
    output logic        dma_flush,
    output logic [3:0]  dma_pm,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic [31:0] xfer_bytes
);

    localparam logic [21:0] MAX_XFER  = 22'(C_MAX_XFER);
    localparam logic [21:0] FIS_BYTES = 22'(C_FIS_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALC,
        REQ,
        REL,
        FIN
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] addr_q;
    logic [21:0] rem_q;
    logic        last_q;
    logic [21:0] fis_rem_q;
    logic [21:0] cur_len_q;
    logic        flush_q;
    logic        wrt_q;
    logic [3:0]  pm_q;

    logic [21:0] lim;
    logic [21:0] calc_len;
    logic [21:0] fis_rem_nxt;

    // Moore outputs decoded from the state; a reset therefore drops dma_req at once.
    assign prd_ready = (state == FETCH) && !cmd_abort;
    assign dma_req   = (state == REQ);
    assign cmd_busy  = (state != IDLE);
    assign cmd_done  = (state == FIN);

    // Burst length is the smallest of PRD remainder, FIS room (transmit only) and C_MAX_XFER.
    always_comb begin
        lim = MAX_XFER;
        if (!wrt_q && (fis_rem_q < MAX_XFER)) begin
            lim = fis_rem_q;
        end
        calc_len    = (rem_q < lim) ? rem_q : lim;
        fis_rem_nxt = fis_rem_q - cur_len_q;
    end

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; REL only moves on once the engine has released dma_ack.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_flush) begin
                    state_nxt = CALC;
                end else if (cmd_start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (cmd_abort) begin
                    state_nxt = FIN;
                end else if (prd_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: state_nxt = REQ;
            REQ: begin
                if (dma_ack) begin
                    state_nxt = REL;
                end
            end
            REL: begin
                if (!dma_ack) begin
                    if (flush_q || cmd_abort) begin
                        state_nxt = FIN;
                    end else if (rem_q != 22'd0) begin
                        state_nxt = CALC;
                    end else if (!last_q) begin
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command/PRD bookkeeping, burst output registers and progress counters.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            addr_q      <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
            fis_rem_q   <= '0;
            cur_len_q   <= '0;
            flush_q     <= 1'b0;
            wrt_q       <= 1'b0;
            pm_q        <= '0;
            xfer_bytes  <= '0;
            dma_address <= '0;
            dma_length  <= '0;
            dma_wrt     <= 1'b0;
            dma_sof     <= 1'b0;
            dma_eof     <= 1'b0;
            dma_data    <= 1'b0;
            dma_flush   <= 1'b0;
            dma_pm      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_flush) begin
                        flush_q <= 1'b1;
                        rem_q   <= '0;
                        last_q  <= 1'b1;
                    end else if (cmd_start) begin
                        flush_q    <= 1'b0;
                        wrt_q      <= cmd_wrt;
                        pm_q       <= cmd_pm;
                        xfer_bytes <= '0;
                        fis_rem_q  <= FIS_BYTES;
                    end
                end
                FETCH: begin
                    if (prd_valid && !cmd_abort) begin
                        addr_q <= prd_addr;
                        rem_q  <= prd_len;
                        last_q <= prd_last;
                    end
                end
                CALC: begin
                    dma_address <= addr_q;
                    dma_wrt     <= wrt_q;
                    dma_pm      <= pm_q;
                    dma_flush   <= flush_q;
                    if (flush_q) begin
                        cur_len_q  <= '0;
                        dma_length <= '0;
                        dma_sof    <= 1'b0;
                        dma_eof    <= 1'b0;
                        dma_data   <= 1'b0;
                    end else begin
                        cur_len_q  <= calc_len;
                        dma_length <= calc_len[15:0];
                        if (wrt_q) begin
                            dma_sof  <= 1'b0;
                            dma_eof  <= 1'b0;
                            dma_data <= 1'b0;
                        end else begin
                            dma_sof  <= (fis_rem_q == FIS_BYTES);
                            dma_data <= (fis_rem_q == FIS_BYTES);
                            dma_eof  <= (calc_len == fis_rem_q) ||
                                        (last_q && (calc_len == rem_q));
                        end
                    end
                end
                REQ: begin
                    if (dma_ack) begin
                        addr_q     <= addr_q + {10'd0, cur_len_q};
                        rem_q      <= rem_q - cur_len_q;
                        xfer_bytes <= xfer_bytes + {10'd0, cur_len_q};
                        if (!wrt_q && !flush_q) begin
                            if ((fis_rem_nxt == 22'd0) || dma_eof) begin
                                fis_rem_q <= FIS_BYTES;
                            end else begin
                                fis_rem_q <= fis_rem_nxt;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
